// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use stall controller for the in-order pipeline
// Optional perf counters (stall_count, fwd_count) are built when HAZ_PERF_CNT_EN is defined.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 3,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          issue_regwrite,
    input  logic                          issue_is_load,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_count,
    output logic [31:0]                   fwd_count
`endif
);

    logic [FWD_DEPTH-1:0]     tag_vld_q, tag_vld_d;
    logic [FWD_DEPTH-1:0]     tag_ld_q, tag_ld_d;
    logic [REG_ADDR_W-1:0]    tag_rd_q [FWD_DEPTH];
    logic [REG_ADDR_W-1:0]    tag_rd_d [FWD_DEPTH];
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
    logic [NUM_SRC*SEL_W-1:0] cand_sel;
    logic [NUM_SRC-1:0]       src_haz;
    logic                     issue_ok;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        cand_sel = '0;
        src_haz  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (src_valid[i] && (src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                    tag_vld_q[k] && (tag_rd_q[k] == src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    cand_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    src_haz[i]                 = tag_ld_q[k] && (k < LOAD_LAT);
                end
            end
        end
    end

    assign stall    = issue_valid & ~flush & (|src_haz);
    assign issue_ok = issue_valid & ~stall & ~flush;
    assign fwd_sel_d = issue_ok ? cand_sel : '0;

    // Flush kills the EX-stage entry as it shifts into entry 1.
    always_comb begin
        tag_vld_d    = '0;
        tag_ld_d     = '0;
        tag_vld_d[0] = issue_ok & issue_regwrite & (issue_rd != '0);
        tag_ld_d[0]  = issue_is_load;
        tag_rd_d[0]  = issue_rd;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1] & ~((k == 1) & flush);
            tag_ld_d[k]  = tag_ld_q[k-1];
            tag_rd_d[k]  = tag_rd_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_ld_q  <= '0;
            fwd_sel_q <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                tag_rd_q[k] <= '0;
            end
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_ld_q  <= tag_ld_d;
            fwd_sel_q <= fwd_sel_d;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                tag_rd_q[k] <= tag_rd_d[k];
            end
        end
    end

    assign fwd_sel = fwd_sel_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((fwd_sel_d != '0) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit (defaults and FWD_DEPTH=3/LOAD_LAT=2)
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv   [2];
    logic [4:0] ird  [2];
    logic       irw  [2];
    logic       ild  [2];
    logic [2:0] sv   [2];
    logic [14:0] sa  [2];
    logic       fl   [2];
    logic       stl  [2];
    logic [5:0] sel  [2];
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stc [2];
    logic [31:0] fwc [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_stalls [2];
    int exp_fwds   [2];
    logic [5:0] exp_q0 [$];
    logic [5:0] exp_q1 [$];

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut_a (
        .clk(clk), .rst(rst),
        .issue_valid(iv[0]), .issue_rd(ird[0]), .issue_regwrite(irw[0]), .issue_is_load(ild[0]),
        .src_valid(sv[0]), .src_addr(sa[0]), .flush(fl[0]),
        .stall(stl[0]), .fwd_sel(sel[0])
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(stc[0]), .fwd_count(fwc[0])
`endif
    );

    fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .issue_valid(iv[1]), .issue_rd(ird[1]), .issue_regwrite(irw[1]), .issue_is_load(ild[1]),
        .src_valid(sv[1]), .src_addr(sa[1]), .flush(fl[1]),
        .stall(stl[1]), .fwd_sel(sel[1])
`ifdef HAZ_PERF_CNT_EN
        , .stall_count(stc[1]), .fwd_count(fwc[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input int d);
        logic [5:0] e;
        if (d == 0 && exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check_eq("fwd_sel_a", {26'd0, sel[0]}, {26'd0, e});
        end else if (d == 1 && exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check_eq("fwd_sel_b", {26'd0, sel[1]}, {26'd0, e});
        end
    endtask

    // One ID cycle: check the previous EX select, drive, check stall, queue the next EX select.
    task automatic step(input int d, input logic v, input logic [4:0] rd, input logic rw,
                        input logic ld, input logic [2:0] s_v, input logic [4:0] a2,
                        input logic [4:0] a1, input logic [4:0] a0, input logic f,
                        input logic es, input logic [5:0] esel);
        @(negedge clk);
        pop_check(d);
        iv[d] = v; ird[d] = rd; irw[d] = rw; ild[d] = ld;
        sv[d] = s_v; sa[d] = {a2, a1, a0}; fl[d] = f;
        #1;
        check_eq(d == 0 ? "stall_a" : "stall_b", {31'd0, stl[d]}, {31'd0, es});
        if (d == 0) exp_q0.push_back(esel);
        else        exp_q1.push_back(esel);
        if (es) exp_stalls[d]++;
        if (esel != 6'd0) exp_fwds[d]++;
    endtask

    task automatic idle(input int d);
        step(d, 0, 5'd0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 6'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 0; ird[d] = 0; irw[d] = 0; ild[d] = 0;
            sv[d] = 0; sa[d] = 0; fl[d] = 0;
            exp_stalls[d] = 0; exp_fwds[d] = 0;
        end
        #2;
        check_eq("reset_stall_a", {31'd0, stl[0]}, 32'd0);
        check_eq("reset_sel_a", {26'd0, sel[0]}, 32'd0);
        check_eq("reset_sel_b", {26'd0, sel[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ALU chain: distance 1
        step(0, 1, 5'd5, 1, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd5, 0, 0, 6'b000001);
        idle(0); idle(0);
        // Distance 2, then youngest of two producers wins
        step(0, 1, 5'd7, 1, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd9, 1, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd7, 0, 0, 6'b000010);
        step(0, 1, 5'd7, 1, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd7, 1, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b010, 0, 5'd7, 0, 0, 0, 6'b000100);
        idle(0); idle(0);
        // Load-use back to back: one stall cycle, bubble, then stage 2
        step(0, 1, 5'd3, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b010, 0, 5'd3, 0, 0, 1, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b010, 0, 5'd3, 0, 0, 0, 6'b001000);
        idle(0); idle(0);
        // Store data with one independent instruction in between
        step(0, 1, 5'd4, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd10, 1, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b100, 5'd4, 0, 0, 0, 0, 6'b100000);
        idle(0); idle(0);
        // x0, invalid source, non-writing producer
        step(0, 1, 5'd0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd0, 0, 0, 6'd0);
        step(0, 1, 5'd6, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b000, 0, 0, 5'd6, 0, 0, 6'd0);
        step(0, 1, 5'd8, 0, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd8, 0, 0, 6'd0);
        idle(0); idle(0);
        // Flush in the load-use cycle wins; the killed load is not forwarded later
        step(0, 1, 5'd3, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b010, 0, 5'd3, 0, 1, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b010, 0, 5'd3, 0, 0, 0, 6'd0);
        idle(0); idle(0);

        // Deeper pipe: back-to-back load-use stalls twice, then stage 3
        step(1, 1, 5'd3, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(1, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd3, 0, 1, 6'd0);
        step(1, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd3, 0, 1, 6'd0);
        step(1, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd3, 0, 0, 6'b000011);
        idle(1); idle(1); idle(1);
        // One independent instruction between: single stall
        step(1, 1, 5'd3, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(1, 1, 5'd11, 1, 0, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(1, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd3, 0, 1, 6'd0);
        step(1, 1, 5'd0, 0, 0, 3'b001, 0, 0, 5'd3, 0, 0, 6'b000011);
        idle(1); idle(1); idle(1);
        @(negedge clk);
        pop_check(0);
        pop_check(1);

`ifdef HAZ_PERF_CNT_EN
        check_eq("stall_count_a", stc[0], exp_stalls[0]);
        check_eq("fwd_count_a", fwc[0], exp_fwds[0]);
        check_eq("stall_count_b", stc[1], exp_stalls[1]);
        check_eq("fwd_count_b", fwc[1], exp_fwds[1]);
`endif

        // Reset in the middle of a load-use stall
        step(0, 1, 5'd3, 1, 1, 3'b000, 0, 0, 0, 0, 0, 6'd0);
        step(0, 1, 5'd0, 0, 0, 3'b010, 0, 5'd3, 0, 0, 1, 6'd0);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_stall", {31'd0, stl[0]}, 32'd0);
        check_eq("rst_mid_sel", {26'd0, sel[0]}, 32'd0);
        exp_q0.delete();
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 5'd0, 0, 0, 3'b010, 0, 5'd3, 0, 0, 0, 6'd0);
        idle(0);
        @(negedge clk);
        pop_check(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

- Parametrised forwarding and load-use hazard controller for the in-order RISC-V pipeline.
- Tracks destination tags of in-flight instructions in an internal tag pipeline, so the datapath supplies only the issuing instruction's info.
- Produces a registered per-source forwarding select for the instruction entering EX, plus a combinational stall when a load result is not yet forwardable.
- Sits between the ID/EX pipeline register and the EX operand muxes, including the store-data mux.

## Interface

Parameters:
- REG_ADDR_W, 5, register address width
- NUM_SRC, 3, source operands per instruction (rs1, rs2, store data)
- FWD_DEPTH, 2, forwardable stages after EX (1 = EX/MEM, 2 = MEM/WB, ...); must be ≥1
- LOAD_LAT, 1, stages a load needs before its data is forwardable; range 0..FWD_DEPTH-1
- SEL_W, $clog2(FWD_DEPTH+1), derived select width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  ID instruction advances to EX this cycle (ignored while stall or flush)
- issue_rd  in  REG_ADDR_W  destination of the ID instruction
- issue_regwrite  in  1  ID instruction writes issue_rd
- issue_is_load  in  1  ID instruction is a load
- src_valid  in  NUM_SRC  per-source "operand is a register read" (decoder-driven; replaces opcode-type decode)
- src_addr  in  NUM_SRC*REG_ADDR_W  source addresses of the ID instruction, source i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- flush  in  1  kill the ID instruction and the EX-stage entry (branch/jump redirect)
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_sel  out  NUM_SRC*SEL_W  per-source select for the instruction now in EX: 0 = register file, k = stage k

## Operation

- Tag pipeline has FWD_DEPTH entries {valid, rd, is_load}, entry 0 = instruction in EX. It shifts every cycle; the oldest entry is dropped.
- Entry 0 loads {issue_valid & issue_regwrite & rd≠0, issue_rd, issue_is_load} when not stall and not flush. Otherwise entry 0 loads invalid (bubble).
- flush also invalidates the current entry 0 before the shift; entries 1.. are unaffected.
- Match for source i: src_valid[i], src_addr≠0, entry valid, entry rd == src_addr. The lowest-index (youngest) matching entry wins.
- Candidate select = matching entry index + 1, i.e. the stage the producer occupies when the consumer reaches EX. No match gives 0. The register file is write-before-read, so a producer past FWD_DEPTH needs no forwarding.
- Load-use hazard: the winning entry is a load and its entry index < LOAD_LAT. Then stall = 1, asserted only when issue_valid = 1 and flush = 0.
- fwd_sel register: loads the candidate selects when issue_valid & !stall & !flush, else loads all-zero (bubble).
- x0 never matches. Stall is re-evaluated each cycle as the load advances; no separate FSM counter is needed.

## Timing

- Reset: all tag entries invalid, fwd_sel = 0, stall = 0, perf counters = 0.
- stall is combinational from ID inputs and tag state in the same cycle.
- fwd_sel has one-cycle latency: computed in ID, valid throughout the consumer's EX cycle.
- With LOAD_LAT = L, a dependent instruction directly behind a load stalls L−j cycles, where j = number of independent instructions between them (minimum 0). Back-to-back load-use with defaults stalls exactly 1 cycle, then fwd_sel = 2.
- flush and a hazard in the same cycle: flush wins; stall = 0 and a bubble is inserted.
- Reset mid-stall: stall drops immediately (asynchronous) and the pipeline is empty.

## Configuration

- HAZ_PERF_CNT_EN defined: adds outputs stall_count (32 bits) and fwd_count (32 bits).
  - stall_count increments every cycle stall = 1.
  - fwd_count increments once per issued instruction with any nonzero select.
  - Both saturate at all-ones and clear on rst.
- HAZ_PERF_CNT_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan

- ALU chain: issue add x5 (rd=5), then next cycle sub reading rs1=5 → stall = 0; sub's EX cycle fwd_sel[0] = 1.
- Distance 2, plus a newer producer of the same register: x7 written two ahead → fwd_sel = 2. When x7 is written both one and two ahead → fwd_sel = 1 (youngest wins).
- Load-use, defaults: lw x3 followed by add reading x3 as src 1 → stall = 1 for exactly one cycle, bubble in EX (fwd_sel = 0), then add's EX cycle fwd_sel[1] = 2.
- Store data: lw x4 then sw with src 2 = x4, one independent instruction between → no stall, fwd_sel[2] = 2.
- x0 and invalid sources: producer rd = 0 or src_valid = 0 on a matching address → fwd_sel = 0, no stall.
- Flush during stall: flush asserted in the load-use stall cycle → stall = 0, next fwd_sel = 0. Dependent instruction issued after the redirect with the load 2 stages old → fwd_sel = 0. With FWD_DEPTH = 3, LOAD_LAT = 2: load-use stall lasts 2 cycles.
